// File: rtl/offnariscv_pkg.sv
// Shared bus constants for the offnariscv core: ACE channel widths and
// AXI response / burst encodings.
package offnariscv_pkg;

  localparam int ACE_AXADDR_WIDTH = 32;
  localparam int ACE_XDATA_WIDTH  = 32;
  localparam int ACE_ID_WIDTH     = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

endpackage

// File: rtl/ace_if.sv
// ACE master/slave bundle: AXI4 read/write channels plus the snoop
// AC/CR/CD channels.
interface ace_if #(
  parameter int AXADDR_WIDTH = offnariscv_pkg::ACE_AXADDR_WIDTH,
  parameter int XDATA_WIDTH  = offnariscv_pkg::ACE_XDATA_WIDTH,
  parameter int ID_WIDTH     = offnariscv_pkg::ACE_ID_WIDTH
);
  logic                      awvalid, awready;
  logic [ID_WIDTH-1:0]       awid;
  logic [AXADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      wvalid, wready, wlast;
  logic [XDATA_WIDTH-1:0]    wdata;
  logic [XDATA_WIDTH/8-1:0]  wstrb;
  logic                      bvalid, bready, buser;
  logic [ID_WIDTH-1:0]       bid;
  logic [1:0]                bresp;
  logic                      arvalid, arready;
  logic [ID_WIDTH-1:0]       arid;
  logic [AXADDR_WIDTH-1:0]   araddr;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      rvalid, rready, rlast, ruser;
  logic [ID_WIDTH-1:0]       rid;
  logic [XDATA_WIDTH-1:0]    rdata;
  logic [3:0]                rresp;
  logic                      acvalid, acready;
  logic [AXADDR_WIDTH-1:0]   acaddr;
  logic [3:0]                acsnoop;
  logic [2:0]                acprot;
  logic                      crvalid, crready;
  logic [4:0]                crresp;
  logic                      cdvalid, cdready, cdlast;
  logic [XDATA_WIDTH-1:0]    cddata;

  modport s (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  acready, crvalid, crresp, cdvalid, cddata, cdlast,
    output awready, wready, bvalid, bid, bresp, buser,
    output arready, rvalid, rid, rdata, rresp, rlast, ruser,
    output acvalid, acaddr, acsnoop, acprot, crready, cdready
  );

  modport m (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output acready, crvalid, crresp, cdvalid, cddata, cdlast,
    input  awready, wready, bvalid, bid, bresp, buser,
    input  arready, rvalid, rid, rdata, rresp, rlast, ruser,
    input  acvalid, acaddr, acsnoop, acprot, crready, cdready
  );
endinterface

// File: rtl/ace_mem_responder_ram.sv
// Single-port RAM, synchronous read with one cycle of latency and
// per-byte write enables. Read data holds until the next read.
module ram_1rw_be #(
  parameter int WORDS = 16384,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [WIDTH/8-1:0]       be,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < WIDTH/8; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/ace_mem_responder.sv
// AXI4 slave memory on the ace_if slave side: one transaction at a time,
// round-robin AR/AW arbitration, full-width beats, snoop channels tied off.
module ace_mem_responder
  import offnariscv_pkg::*;
#(
  parameter int                          MEM_BYTES = 65536,
  parameter logic [ACE_AXADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000
) (
  input logic clk,
  input logic rst,
  ace_if.s    mem_ace_if
);
  localparam int A        = ACE_AXADDR_WIDTH;
  localparam int D        = ACE_XDATA_WIDTH;
  localparam int I        = ACE_ID_WIDTH;
  localparam int NB       = D / 8;
  localparam int WORDS    = MEM_BYTES / NB;
  localparam int IDX_W    = $clog2(WORDS);
  localparam int OFFS_LSB = $clog2(NB);

  typedef enum logic [1:0] {IDLE, READ, WRITE, BRESP} state_e;

  state_e         state;
  logic           last_was_read;
  logic [I-1:0]   id_q;
  logic [A-1:0]   addr_q;
  logic [7:0]     len_q, beat_cnt;
  logic [1:0]     burst_q;
  logic           rvalid_p1, rlast_p1;
  logic [1:0]     rresp_p1;
  logic [I-1:0]   rid_p1;
  logic [D-1:0]   ram_q_p1;
  logic           wready_q, bvalid_q, decerr_q, slverr_q;
  logic [1:0]     bresp_q;
  logic [I-1:0]   bid_q;

  function automatic logic addr_in_range(input logic [A-1:0] a);
    return (a - BASE_ADDR) < A'(MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [A-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFFS_LSB);
  endfunction

  // WRAP bursts are served as INCR.
  function automatic logic [A-1:0] next_addr(input logic [A-1:0] a, input logic [1:0] burst);
    return (burst == AXI_BURST_FIXED) ? a : a + A'(NB);
  endfunction

  function automatic logic [1:0] resp_merge(input logic dec, input logic slv);
    return dec ? AXI_RESP_DECERR : (slv ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
  endfunction

  logic           ar_win, aw_win, rd_issue, w_beat, w_end, w_proto_err, w_in_range;
  logic [A-1:0]   rd_addr;
  logic [7:0]     rd_cnt;
  logic           ram_en;
  logic [IDX_W-1:0] ram_addr;

  // Read wins unless the previous transaction was a read and a write waits.
  assign ar_win = (state == IDLE) && !rst && mem_ace_if.arvalid &&
                  (!mem_ace_if.awvalid || !last_was_read);
  assign aw_win = (state == IDLE) && !rst && mem_ace_if.awvalid && !ar_win;

  // The next beat is fetched in the cycle the current one is accepted.
  assign rd_issue = (state == READ) &&
                    (!rvalid_p1 || (mem_ace_if.rready && !rlast_p1));
  assign rd_addr  = rvalid_p1 ? next_addr(addr_q, burst_q) : addr_q;
  assign rd_cnt   = rvalid_p1 ? beat_cnt + 8'd1 : beat_cnt;

  assign w_beat      = wready_q && mem_ace_if.wvalid;
  assign w_in_range  = addr_in_range(addr_q);
  assign w_end       = (beat_cnt == len_q) || mem_ace_if.wlast;
  assign w_proto_err = mem_ace_if.wlast != (beat_cnt == len_q);

  assign ram_en   = (rd_issue && addr_in_range(rd_addr)) || (w_beat && w_in_range);
  assign ram_addr = (state == READ) ? word_idx(rd_addr) : word_idx(addr_q);

  ram_1rw_be #(.WORDS(WORDS), .WIDTH(D)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (w_beat),
    .be    (mem_ace_if.wstrb),
    .addr  (ram_addr),
    .wdata (mem_ace_if.wdata),
    .rdata (ram_q_p1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_was_read <= 1'b0;
      rvalid_p1     <= 1'b0;
      rlast_p1      <= 1'b0;
      rresp_p1      <= AXI_RESP_OKAY;
      rid_p1        <= '0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= AXI_RESP_OKAY;
      bid_q         <= '0;
      decerr_q      <= 1'b0;
      slverr_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_win) begin
            id_q     <= mem_ace_if.arid;
            addr_q   <= mem_ace_if.araddr;
            len_q    <= mem_ace_if.arlen;
            burst_q  <= mem_ace_if.arburst;
            beat_cnt <= '0;
            state    <= READ;
          end else if (aw_win) begin
            id_q     <= mem_ace_if.awid;
            addr_q   <= mem_ace_if.awaddr;
            len_q    <= mem_ace_if.awlen;
            burst_q  <= mem_ace_if.awburst;
            beat_cnt <= '0;
            wready_q <= 1'b1;
            state    <= WRITE;
          end
        end
        // p1: RAM output and beat attributes become visible together
        READ: begin
          if (rd_issue) begin
            addr_q    <= rd_addr;
            beat_cnt  <= rd_cnt;
            rvalid_p1 <= 1'b1;
            rlast_p1  <= (rd_cnt == len_q);
            rresp_p1  <= addr_in_range(rd_addr) ? AXI_RESP_OKAY : AXI_RESP_DECERR;
            rid_p1    <= id_q;
          end else if (rvalid_p1 && mem_ace_if.rready && rlast_p1) begin
            rvalid_p1     <= 1'b0;
            last_was_read <= 1'b1;
            state         <= IDLE;
          end
        end
        WRITE: begin
          if (w_beat) begin
            if (!w_in_range) decerr_q <= 1'b1;
            if (w_proto_err) slverr_q <= 1'b1;
            if (w_end) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= resp_merge(decerr_q || !w_in_range, slverr_q || w_proto_err);
              state    <= BRESP;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              addr_q   <= next_addr(addr_q, burst_q);
            end
          end
        end
        BRESP: begin
          if (mem_ace_if.bready) begin
            bvalid_q      <= 1'b0;
            last_was_read <= 1'b0;
            decerr_q      <= 1'b0;
            slverr_q      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_ace_if.arready = ar_win;
  assign mem_ace_if.awready = aw_win;
  assign mem_ace_if.wready  = wready_q;
  assign mem_ace_if.bvalid  = bvalid_q;
  assign mem_ace_if.bid     = bid_q;
  assign mem_ace_if.bresp   = bresp_q;
  assign mem_ace_if.rvalid  = rvalid_p1;
  assign mem_ace_if.rid     = rid_p1;
  assign mem_ace_if.rlast   = rlast_p1;
  assign mem_ace_if.rresp   = {2'b00, rresp_p1};
  assign mem_ace_if.rdata   = (rvalid_p1 && rresp_p1 == AXI_RESP_OKAY) ? ram_q_p1 : '0;

  assign mem_ace_if.buser   = 1'b0;
  assign mem_ace_if.ruser   = 1'b0;
  assign mem_ace_if.acvalid = 1'b0;
  assign mem_ace_if.acaddr  = '0;
  assign mem_ace_if.acsnoop = '0;
  assign mem_ace_if.acprot  = '0;
  assign mem_ace_if.crready = 1'b1;
  assign mem_ace_if.cdready = 1'b1;

  logic unused_sampled;
  assign unused_sampled = ^{mem_ace_if.awsize, mem_ace_if.arsize, mem_ace_if.acready,
                            mem_ace_if.crvalid, mem_ace_if.crresp, mem_ace_if.cdvalid,
                            mem_ace_if.cddata, mem_ace_if.cdlast};
endmodule

// File: tb/tb_ace_mem_responder.sv
// Directed bench for ace_mem_responder: reset state, arbitration, single and
// burst transfers, byte strobes, decode errors, protocol errors, reset mid-burst.
module tb_ace_mem_responder;
  import offnariscv_pkg::*;

  logic clk, rst;
  int   vecs = 0;
  int   miscompares = 0;

  ace_if mem_if ();

  ace_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ace_if (mem_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] rd_data [8];
  logic [3:0]  rd_resp [8];
  logic        rd_last [8];
  logic [3:0]  rd_id   [8];
  int          rd_wait;
  int          b_wait_cyc;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    int n;
    mem_if.araddr  = a;
    mem_if.arlen   = len;
    mem_if.arid    = id;
    mem_if.arburst = AXI_BURST_INCR;
    mem_if.arsize  = 3'd2;
    mem_if.arvalid = 1'b1;
    #1;
    n = 0;
    while (!mem_if.arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("ar_handshake", 64'(mem_if.arready), 64'(1));
    @(negedge clk); #1;
    mem_if.arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    int n;
    mem_if.awaddr  = a;
    mem_if.awlen   = len;
    mem_if.awid    = id;
    mem_if.awburst = AXI_BURST_INCR;
    mem_if.awsize  = 3'd2;
    mem_if.awvalid = 1'b1;
    #1;
    n = 0;
    while (!mem_if.awready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("aw_handshake", 64'(mem_if.awready), 64'(1));
    @(negedge clk); #1;
    mem_if.awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] strb, input logic last);
    int n;
    mem_if.wdata  = d;
    mem_if.wstrb  = strb;
    mem_if.wlast  = last;
    mem_if.wvalid = 1'b1;
    #1;
    n = 0;
    while (!mem_if.wready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("w_handshake", 64'(mem_if.wready), 64'(1));
    @(negedge clk); #1;
    mem_if.wvalid = 1'b0;
    mem_if.wlast  = 1'b0;
  endtask

  task automatic b_wait();
    int n;
    mem_if.bready = 1'b1;
    n = 0;
    while (!mem_if.bvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("b_handshake", 64'(mem_if.bvalid), 64'(1));
    b_resp     = mem_if.bresp;
    b_id       = mem_if.bid;
    b_wait_cyc = n;
    @(negedge clk); #1;
    mem_if.bready = 1'b0;
  endtask

  // toggle=1 drives rready 1,0,1,0... from the first valid cycle and checks
  // that the presented beat holds across each stalled cycle.
  task automatic r_collect(input int n_beats, input bit toggle);
    int got, cyc, guard;
    logic [40:0] hold;
    bit stalled;
    got = 0; cyc = 0; guard = 0; stalled = 0; hold = '0;
    mem_if.rready = 1'b0;
    rd_wait = 0;
    while (!mem_if.rvalid && rd_wait < 20) begin
      @(negedge clk); #1; rd_wait++;
    end
    check("r_arrive", 64'(mem_if.rvalid), 64'(1));
    while (got < n_beats && guard < 40) begin
      mem_if.rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled) begin
        check("r_stable", 64'({mem_if.rid, mem_if.rresp, mem_if.rlast, mem_if.rdata}), 64'(hold));
        stalled = 0;
      end
      if (mem_if.rvalid && mem_if.rready) begin
        rd_data[got] = mem_if.rdata;
        rd_resp[got] = mem_if.rresp;
        rd_last[got] = mem_if.rlast;
        rd_id[got]   = mem_if.rid;
        got++;
      end else if (mem_if.rvalid) begin
        hold    = {mem_if.rid, mem_if.rresp, mem_if.rlast, mem_if.rdata};
        stalled = 1;
      end
      @(negedge clk); #1;
      cyc++; guard++;
    end
    mem_if.rready = 1'b0;
    check("r_beats", 64'(got), 64'(n_beats));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    mem_if.awvalid = 0; mem_if.awid = '0; mem_if.awaddr = '0; mem_if.awlen = '0;
    mem_if.awsize = '0; mem_if.awburst = '0;
    mem_if.wvalid = 0; mem_if.wdata = '0; mem_if.wstrb = '0; mem_if.wlast = 0;
    mem_if.bready = 0;
    mem_if.arvalid = 0; mem_if.arid = '0; mem_if.araddr = '0; mem_if.arlen = '0;
    mem_if.arsize = '0; mem_if.arburst = '0;
    mem_if.rready = 0;
    mem_if.acready = 0; mem_if.crvalid = 0; mem_if.crresp = '0;
    mem_if.cdvalid = 0; mem_if.cddata = '0; mem_if.cdlast = 0;

    // Reset state with both requests already pending
    repeat (3) @(negedge clk);
    #1;
    mem_if.araddr = 32'h8000_0200; mem_if.arlen = 8'd0; mem_if.arid = 4'd1;
    mem_if.arburst = AXI_BURST_INCR; mem_if.arvalid = 1'b1;
    mem_if.awaddr = 32'h8000_0300; mem_if.awlen = 8'd0; mem_if.awid = 4'd2;
    mem_if.awburst = AXI_BURST_INCR; mem_if.awvalid = 1'b1;
    #1;
    check("rst_arready", 64'(mem_if.arready), 64'(0));
    check("rst_awready", 64'(mem_if.awready), 64'(0));
    check("rst_rvalid",  64'(mem_if.rvalid),  64'(0));
    check("rst_bvalid",  64'(mem_if.bvalid),  64'(0));
    check("rst_wready",  64'(mem_if.wready),  64'(0));
    check("rst_rdata",   64'(mem_if.rdata),   64'(0));
    check("rst_rresp",   64'(mem_if.rresp),   64'(0));
    check("rst_rlast",   64'(mem_if.rlast),   64'(0));
    check("rst_rid",     64'(mem_if.rid),     64'(0));
    check("rst_bid",     64'(mem_if.bid),     64'(0));
    check("rst_bresp",   64'(mem_if.bresp),   64'(0));
    check("tie_crready", 64'(mem_if.crready), 64'(1));
    check("tie_acvalid", 64'(mem_if.acvalid), 64'(0));

    // Arbitration: read first after reset, then alternate
    rst = 1'b0;
    #1;
    check("arb_first_arready", 64'(mem_if.arready), 64'(1));
    check("arb_first_awready", 64'(mem_if.awready), 64'(0));
    @(negedge clk); #1;
    mem_if.arvalid = 1'b0;
    check("busy_awready", 64'(mem_if.awready), 64'(0));
    r_collect(1, 0);
    check("arb_rd_rid",   64'(rd_id[0]),   64'(4'd1));
    check("arb_rd_rlast", 64'(rd_last[0]), 64'(1));
    mem_if.araddr = 32'h8000_0300; mem_if.arid = 4'd4; mem_if.arvalid = 1'b1;
    #1;
    check("arb_alt_awready", 64'(mem_if.awready), 64'(1));
    check("arb_alt_arready", 64'(mem_if.arready), 64'(0));
    @(negedge clk); #1;
    mem_if.awvalid = 1'b0;
    w_send(32'h1111_1111, 4'hF, 1'b1);
    b_wait();
    check("arb_wr_bresp", 64'(b_resp), 64'(AXI_RESP_OKAY));
    check("arb_wr_bid",   64'(b_id),   64'(4'd2));
    mem_if.awaddr = 32'h8000_0400; mem_if.awvalid = 1'b1;
    #1;
    check("arb_alt2_arready", 64'(mem_if.arready), 64'(1));
    check("arb_alt2_awready", 64'(mem_if.awready), 64'(0));
    @(negedge clk); #1;
    mem_if.arvalid = 1'b0;
    mem_if.awvalid = 1'b0;
    r_collect(1, 0);
    check("arb_rd2_data", 64'(rd_data[0]), 64'(32'h1111_1111));
    check("arb_rd2_rid",  64'(rd_id[0]),   64'(4'd4));

    // Single write then read
    aw_send(32'h8000_0010, 8'd0, 4'd3);
    w_send(32'hDEAD_BEEF, 4'hF, 1'b1);
    b_wait();
    check("wr1_b_latency", 64'(b_wait_cyc), 64'(0));
    check("wr1_bresp",     64'(b_resp),     64'(AXI_RESP_OKAY));
    check("wr1_bid",       64'(b_id),       64'(4'd3));
    ar_send(32'h8000_0010, 8'd0, 4'd5);
    r_collect(1, 0);
    check("rd1_latency", 64'(rd_wait),    64'(1));
    check("rd1_data",    64'(rd_data[0]), 64'(32'hDEAD_BEEF));
    check("rd1_rlast",   64'(rd_last[0]), 64'(1));
    check("rd1_rresp",   64'(rd_resp[0]), 64'(0));
    check("rd1_rid",     64'(rd_id[0]),   64'(4'd5));

    // Byte strobe merge
    aw_send(32'h8000_0010, 8'd0, 4'd3);
    w_send(32'h0000_00AA, 4'h1, 1'b1);
    b_wait();
    ar_send(32'h8000_0010, 8'd0, 4'd5);
    r_collect(1, 0);
    check("strb_data", 64'(rd_data[0]), 64'(32'hDEAD_BEAA));

    // INCR burst, read back under rready backpressure
    aw_send(32'h8000_0100, 8'd3, 4'd6);
    w_send(32'd1, 4'hF, 1'b0);
    w_send(32'd2, 4'hF, 1'b0);
    w_send(32'd3, 4'hF, 1'b0);
    w_send(32'd4, 4'hF, 1'b1);
    b_wait();
    check("burst_bresp", 64'(b_resp), 64'(AXI_RESP_OKAY));
    ar_send(32'h8000_0100, 8'd3, 4'd7);
    r_collect(4, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst_data%0d", i), 64'(rd_data[i]), 64'(i + 1));
      check($sformatf("burst_last%0d", i), 64'(rd_last[i]), 64'(i == 3));
    end

    // Out-of-range read and write
    ar_send(32'h0000_0000, 8'd0, 4'd8);
    r_collect(1, 0);
    check("oor_rresp", 64'(rd_resp[0]), 64'(4'h3));
    check("oor_rdata", 64'(rd_data[0]), 64'(0));
    aw_send(32'h0000_0010, 8'd0, 4'd12);
    w_send(32'h1234_5678, 4'hF, 1'b1);
    b_wait();
    check("oor_bresp", 64'(b_resp), 64'(AXI_RESP_DECERR));
    check("oor_bid",   64'(b_id),   64'(4'd12));
    ar_send(32'h8000_0010, 8'd0, 4'd5);
    r_collect(1, 0);
    check("oor_ram_unchanged", 64'(rd_data[0]), 64'(32'hDEAD_BEAA));

    // Early wlast on a 4-beat write
    aw_send(32'h8000_0200, 8'd3, 4'd9);
    w_send(32'hA5A5_A5A5, 4'hF, 1'b0);
    w_send(32'h5A5A_5A5A, 4'hF, 1'b1);
    b_wait();
    check("proto_b_latency", 64'(b_wait_cyc), 64'(0));
    check("proto_bresp",     64'(b_resp),     64'(AXI_RESP_SLVERR));
    check("proto_bid",       64'(b_id),       64'(4'd9));

    // Reset in the middle of a read burst
    ar_send(32'h8000_0100, 8'd3, 4'd10);
    n = 0;
    while (!mem_if.rvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("rstmid_pre_rvalid", 64'(mem_if.rvalid), 64'(1));
    rst = 1'b1;
    @(negedge clk); #1;
    check("rstmid_rvalid", 64'(mem_if.rvalid), 64'(0));
    mem_if.araddr = 32'h8000_0100; mem_if.arlen = 8'd0; mem_if.arid = 4'd11;
    mem_if.arvalid = 1'b1;
    #1;
    check("rstmid_arready_in_rst", 64'(mem_if.arready), 64'(0));
    rst = 1'b0;
    #1;
    check("rstmid_arready_back", 64'(mem_if.arready), 64'(1));
    @(negedge clk); #1;
    mem_if.arvalid = 1'b0;
    r_collect(1, 0);
    check("rstmid_rd_data", 64'(rd_data[0]), 64'(1));
    check("rstmid_rd_rid",  64'(rd_id[0]),   64'(4'd11));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule

// File: doc/ace_mem_responder.md
# ace_mem_responder

Single-port memory responder on the `ace_if` slave side, i.e. the far end of the LSU/fetch master ports. It accepts AR/AW/W requests, serves them from an internal byte-enable RAM, and returns R/B responses. It is the memory model for core-level simulation and the on-chip scratchpad for FPGA builds. Snoop channels are tied off; the responder behaves as a plain AXI4 slave.

## Interface
- `MEM_BYTES`, default 65536: RAM size in bytes. Must be a power of two and a multiple of `ACE_XDATA_WIDTH/8`.
- `BASE_ADDR`, default 32'h8000_0000: first byte address served. Must be aligned to `MEM_BYTES`.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset; synchronous, active-high.
- `mem_ace_if`, `ace_if.s`, interface: AXADDR width A, XDATA width D, ID width I.
  - Driven by this block: `awready`, `wready`, `bvalid`, `bid`, `bresp`, `buser`, `arready`, `rvalid`, `rid`, `rdata`, `rresp`, `rlast`, `ruser`, `acvalid`, `acaddr`, `acsnoop`, `acprot`, `crready`, `cdready`.
  - All other signals are sampled.

## Operation
- **States:** IDLE, READ, WRITE, BRESP.
- **IDLE:**
  - Arbitration between a pending `arvalid` and a pending `awvalid` is round-robin, using a 1-bit `last_was_read` flag.
  - With only one request pending, that request wins.
  - The winner's ready is asserted combinationally in the same cycle, and only in IDLE.
  - On handshake the block captures id, addr, len and burst, clears `beat_cnt`, and moves to READ or WRITE.
- **Address:**
  - `word_idx = (addr - BASE_ADDR) >> log2(D/8)`.
  - `in_range = (addr - BASE_ADDR) < MEM_BYTES`; the range check is evaluated per beat.
  - Each beat is full-width; `axsize` is ignored.
  - FIXED (burst 2'b00): the address stays constant. INCR (2'b01) and WRAP (2'b10) add D/8 per beat. WRAP is treated as INCR.
- **READ:**
  - A RAM read is issued, and data appears one cycle later into the `rdata` holding register.
  - Response fields: `rvalid`=1, `rid`=captured id, `rlast`=(`beat_cnt`==len).
  - `rresp[1:0]`=2'b00 OKAY, or 2'b11 DECERR when out of range; in the DECERR case `rdata`=0.
  - `rresp[3:2]`=0.
  - On `rvalid && rready`, the address advances and the next RAM read is issued in the same cycle. This gives a back-to-back beat next cycle.
  - After the last beat: return to IDLE and set `last_was_read`=1.
- **WRITE:**
  - `wready`=1 throughout the state.
  - Each `wvalid && wready` beat writes `wdata` under `wstrb` when in range. An out-of-range beat is dropped and sets the sticky `decerr` flag.
  - A beat with `wlast`=1 where `beat_cnt`!=len, or `beat_cnt`==len with `wlast`=0, sets the sticky `slverr` flag.
  - The burst ends on whichever comes first: `beat_cnt`==len, or `wlast`=1. It then goes to BRESP.
- **BRESP:**
  - `bvalid`=1, `bid`=captured id.
  - `bresp`: DECERR if `decerr`, else SLVERR (2'b10) if `slverr`, else OKAY.
  - On `bready`: return to IDLE, set `last_was_read`=0, clear the flags.
- **Tie-offs:** `acvalid`, `acaddr`, `acsnoop`, `acprot`, `buser`, `ruser` are 0; `crready`=`cdready`=1.

## Timing
- **Reset:** state IDLE. `rvalid`, `bvalid`, `wready` and `last_was_read` are 0. `rdata`, `rid`, `bid`, `rresp`, `bresp` and `rlast` are 0.
- **Ready during reset:** `arready`/`awready` are 0 while `rst`=1.
- **RAM contents:** not reset.
- **Read latency:** AR handshake at cycle t gives `rvalid` at t+2.
  - Sustained throughput is 1 beat/cycle with `rready` held high.
  - When `rready` is low, `rdata`/`rresp`/`rlast`/`rid` stay stable.
- **Write latency:**
  - AW handshake at t puts `wready` at t+1.
  - The last W beat at t' puts `bvalid` at t'+1.
  - A write is visible to a read whose AR handshakes at or after the `bvalid` cycle.
- **One transaction at a time:** no read/write overlap and no outstanding queue. AR/AW ready stay low outside IDLE.
- **Simultaneous AR and AW in IDLE:** exactly one ready rises, per `last_was_read`; after reset, read wins first.
- **W before AW:** a W beat presented before AW is not accepted, because `wready` is low in IDLE.
- **Reset mid-burst:** abandon immediately, return to IDLE, drop the response. The master is reset in the same cycle.

## Structure
- **Package `offnariscv_pkg`:** gains `AXI_RESP_OKAY`=2'b00, `AXI_RESP_SLVERR`=2'b10, `AXI_RESP_DECERR`=2'b11, and `AXI_BURST_FIXED`/`INCR`/`WRAP`.
- **Local to the module:** the state enum.
- **Sub-module `ram_1rw_be`:** parameters WORDS and WIDTH; single port, synchronous read, 1-cycle latency, byte write-enable. It is instantiated once. Read and write never happen in the same cycle, so one port suffices.

## Test plan
- **Single write then read:** AW 0x8000_0010 len 0, W data 0xDEADBEEF with wstrb 0xF (D=32) gives `bresp` OKAY, `bid`=AW id. AR to the same address gives `rvalid` at t+2 with `rdata` 0xDEADBEEF and `rlast`=1.
- **Byte strobes:** after the write above, writing 0x000000AA with wstrb 0x1 then reading gives 0xDEADBEAA.
- **INCR burst with backpressure:** write 4 beats 1,2,3,4 from 0x8000_0100. A 4-beat read with `rready` toggling 1,0,1,0 returns 1..4 in order, data stable while stalled, and `rlast` only on beat 4.
- **Arbitration:** `arvalid` and `awvalid` both held from reset gives read granted first, then write. Repeated simultaneous requests alternate.
- **Out-of-range access:** AR 0x0000_0000 gives `rresp` 2'b11 and `rdata` 0. A write there gives `bresp` 2'b11, and RAM is unchanged.
- **Protocol error and reset:** AW len 3 with `wlast` on beat 2 gives `bresp` SLVERR after 2 beats. Asserting `rst` mid-read-burst leaves `rvalid`=0 the next cycle, with `arready` back after reset deasserts.
